// File: rtl/tagger_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; entries hold registered words so dout has no input path.
// Push while full and pop while empty are ignored; full is judged before any same-cycle pop.
module tagger_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers differ only in the wrap bit when every slot is occupied.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/tagger_timestamp_extender.sv
// Extends the 16-bit tagger counter with a rollover epoch and queues {timestamp, channel}
// words for a valid/ready readout; events arriving at a full queue are counted and dropped.
module tagger_timestamp_extender #(
    parameter int EPOCH_W    = 32,
    parameter int CH_W       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          counter,
    input  logic                 rollover,
    input  logic                 event_valid,
    input  logic [CH_W-1:0]      event_channel,
    output logic                 tag_valid,
    input  logic                 tag_ready,
    output logic [EPOCH_W+15:0]  tag_time,
    output logic [CH_W-1:0]      tag_channel,
    output logic                 overflow,
    output logic [DROP_W-1:0]    dropped,
    output logic [EPOCH_W-1:0]   epoch
);

    localparam int TS_W  = EPOCH_W + 16;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic [DROP_W-1:0]    dropped_q, dropped_d;
    logic                 overflow_q, overflow_d;
    logic [EPOCH_W-1:0]   eff_epoch;
    logic [TS_W-1:0]      stamp;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic [TS_W+CH_W-1:0] fifo_dout;

    // An event in the rollover cycle already belongs to the new epoch.
    assign eff_epoch = epoch_q + EPOCH_W'(rollover);
    assign stamp     = {eff_epoch, counter};
    assign drop      = event_valid && fifo_full;

    always_comb begin
        epoch_d    = eff_epoch;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (!(&dropped_q)) dropped_d = dropped_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            epoch_q    <= epoch_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    tagger_sync_fifo #(
        .WIDTH (TS_W + CH_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (event_valid),
        .din   ({stamp, event_channel}),
        .full  (fifo_full),
        .pop   (tag_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign tag_valid               = !fifo_empty;
    assign {tag_time, tag_channel} = fifo_dout;
    assign overflow                = overflow_q;
    assign dropped                 = dropped_q;
    assign epoch                   = epoch_q;

endmodule

// File: tb/tb_tagger_timestamp_extender.sv
// Directed bench for tagger_timestamp_extender: epoch tracking, stamping, FIFO full/drop and async reset.
module tb_tagger_timestamp_extender;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] counter;
    logic        rollover;
    logic        event_valid;
    logic [3:0]  event_channel;
    logic        tag_valid;
    logic        tag_ready;
    logic [47:0] tag_time;
    logic [3:0]  tag_channel;
    logic        overflow;
    logic [15:0] dropped;
    logic [31:0] epoch;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tagger_timestamp_extender #(
        .EPOCH_W(32), .CH_W(4), .FIFO_DEPTH(8), .DROP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .counter(counter), .rollover(rollover),
        .event_valid(event_valid), .event_channel(event_channel),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_time(tag_time),
        .tag_channel(tag_channel), .overflow(overflow), .dropped(dropped),
        .epoch(epoch)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pops;

    initial begin
        rst = 1'b1; counter = 16'h0; rollover = 1'b0;
        event_valid = 1'b0; event_channel = 4'h0; tag_ready = 1'b0;
        tick(); tick();
        check("rst_epoch", 64'(epoch), 64'd0);
        check("rst_valid", 64'(tag_valid), 64'd0);
        check("rst_time", 64'(tag_time), 64'd0);
        check("rst_chan", 64'(tag_channel), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        // Idle counting with rollover pulses.
        counter = 16'h0; rollover = 1'b1; tick();
        check("epoch_1", 64'(epoch), 64'd1);
        rollover = 1'b0;
        counter = 16'h7FFF; tick();
        counter = 16'hFFFF; tick();
        check("epoch_hold", 64'(epoch), 64'd1);
        counter = 16'h0; rollover = 1'b1; tick();
        check("epoch_2", 64'(epoch), 64'd2);
        check("idle_valid", 64'(tag_valid), 64'd0);
        tick();
        rollover = 1'b0;
        check("epoch_3", 64'(epoch), 64'd3);

        // Single event, immediately drained.
        tag_ready = 1'b1;
        counter = 16'h1234; event_valid = 1'b1; event_channel = 4'd2; tick();
        event_valid = 1'b0; counter = 16'h1235;
        check("ev1_valid", 64'(tag_valid), 64'd1);
        check("ev1_time", 64'(tag_time), 64'h0000_0003_1234);
        check("ev1_chan", 64'(tag_channel), 64'd2);
        tick();
        check("ev1_drained", 64'(tag_valid), 64'd0);

        // Event in the rollover cycle.
        rollover = 1'b1; counter = 16'h0;
        for (int i = 0; i < 4; i++) tick();
        rollover = 1'b0;
        check("epoch_7", 64'(epoch), 64'd7);
        tag_ready = 1'b0;
        counter = 16'h0; rollover = 1'b1; event_valid = 1'b1; event_channel = 4'd5; tick();
        rollover = 1'b0; event_valid = 1'b0; counter = 16'h1;
        check("roll_ev_time", 64'(tag_time), 64'h0000_0008_0000);
        check("roll_ev_chan", 64'(tag_channel), 64'd5);
        check("epoch_8", 64'(epoch), 64'd8);
        tag_ready = 1'b1; tick();
        check("roll_ev_drained", 64'(tag_valid), 64'd0);

        // Ten events into an eight-entry queue with no readout.
        tag_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            counter = 16'h0100 + 16'(i); event_valid = 1'b1; event_channel = 4'(i); tick();
            if (i == 0) begin
                check("stall_head_time", 64'(tag_time), 64'h0000_0008_0100);
            end
        end
        event_valid = 1'b0;
        check("stall_head_chan", 64'(tag_channel), 64'd0);
        check("stall_head_time2", 64'(tag_time), 64'h0000_0008_0100);
        check("burst_overflow", 64'(overflow), 64'd1);
        check("burst_dropped", 64'(dropped), 64'd2);
        tag_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 64'(tag_valid), 64'd1);
            check("drain_chan", 64'(tag_channel), 64'(i));
            check("drain_time", 64'(tag_time), 64'h0000_0008_0000 + 64'h100 + 64'(i));
            tick();
        end
        check("drain_empty", 64'(tag_valid), 64'd0);

        // Full queue with a pop and an event in the same cycle: the event is dropped.
        tag_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            counter = 16'h0200 + 16'(i); event_valid = 1'b1; event_channel = 4'(i); tick();
        end
        check("full_dropped_pre", 64'(dropped), 64'd2);
        tag_ready = 1'b1; counter = 16'h0300; event_valid = 1'b1; event_channel = 4'd9; tick();
        event_valid = 1'b0;
        check("full_pop_dropped", 64'(dropped), 64'd3);
        check("full_pop_head", 64'(tag_channel), 64'd1);
        pops = 0;
        for (int i = 0; i < 20 && tag_valid; i++) begin
            check("full_pop_chan", 64'(tag_channel), 64'(pops + 1));
            pops++;
            tick();
        end
        check("full_pop_occupancy", 64'(pops), 64'd7);
        check("full_pop_empty", 64'(tag_valid), 64'd0);

        // Asynchronous reset with five words queued.
        tag_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            counter = 16'h0400 + 16'(i); event_valid = 1'b1; event_channel = 4'(i); tick();
        end
        event_valid = 1'b0;
        check("pre_rst_valid", 64'(tag_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(tag_valid), 64'd0);
        check("async_rst_epoch", 64'(epoch), 64'd0);
        check("async_rst_dropped", 64'(dropped), 64'd0);
        check("async_rst_overflow", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        counter = 16'h0055; event_valid = 1'b1; event_channel = 4'd3; tick();
        event_valid = 1'b0;
        check("post_rst_valid", 64'(tag_valid), 64'd1);
        check("post_rst_time", 64'(tag_time), 64'h0000_0000_0055);
        check("post_rst_chan", 64'(tag_channel), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tagger_timestamp_extender.md
Name: tagger_timestamp_extender

Overview:
Consumer side of the free-running 16-bit tagger counter and its rollover flag. It keeps an epoch count of rollovers and turns each channel event into a wide timestamp {epoch, counter} with a channel ID. The timestamps go through a small FIFO to a valid/ready readout interface that feeds the host transfer path.

Parameters:
EPOCH_W, 32, width of the epoch (rollover) count; timestamp width is EPOCH_W+16
CH_W, 4, width of the channel ID
FIFO_DEPTH, 8, output FIFO depth in entries; must be a power of two, at least 2
DROP_W, 16, width of the dropped-event counter

Ports:
clk  in  1  system clock; same clock as the tagger counter
rst  in  1  asynchronous reset, active-high
counter  in  16  registered tagger counter value
rollover  in  1  high for exactly the one cycle in which counter reads 16'h0000 after a wrap
event_valid  in  1  a channel event occurred this cycle
event_channel  in  CH_W  channel ID, sampled while event_valid is high
tag_valid  out  1  output word available
tag_ready  in  1  downstream accepts the word
tag_time  out  EPOCH_W+16  extended timestamp
tag_channel  out  CH_W  channel ID of the output word
overflow  out  1  sticky; set when an event is dropped
dropped  out  DROP_W  saturating count of dropped events
epoch  out  EPOCH_W  current epoch register, for debug and host readback

Behaviour:
- Reset (asynchronous, active-high) values:
  - epoch=0, dropped=0, overflow=0, tag_valid=0.
  - FIFO empty, read and write pointers 0.
  - tag_time and tag_channel = 0.
- Epoch tracking:
  - When rollover=1: epoch <= epoch+1, wrapping modulo 2^EPOCH_W with no flag.
  - When rollover=0: epoch holds.
- Timestamp formation, combinational on the input cycle:
  - eff_epoch = epoch + rollover.
  - stamp = {eff_epoch, counter}.
  - An event in the same cycle as rollover (counter=0) belongs to the new epoch. Example: epoch 5, counter 0, rollover 1 gives stamp {6, 0x0000}.
- Capture:
  - If event_valid=1 and the FIFO is not full, write {stamp, event_channel} at the end of the cycle.
  - Only one event per cycle.
- Full FIFO:
  - An event arriving while the FIFO is full is dropped.
  - overflow <= 1 and stays set until reset.
  - dropped <= dropped+1, saturating at all-ones.
- Full with simultaneous pop:
  - Full is judged before the pop in the same cycle.
  - If tag_valid and tag_ready are both high while the FIFO is full, an incoming event is still dropped.
  - This rule is fixed and the bench checks it.
- Output handshake:
  - tag_valid = FIFO not empty.
  - tag_time and tag_channel show the head entry; they are registered FIFO storage, so no combinational path from the inputs.
  - A word is popped on the rising edge where tag_valid and tag_ready are both high.
  - While tag_valid=1 and tag_ready=0, the output word must not change.
- Latency: an event in cycle N gives tag_valid=1 in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop on a non-empty, non-full FIFO: the occupancy count is unchanged.
- Empty FIFO with tag_ready=1: no pop and no pointer movement.
- Pointers: log2(FIFO_DEPTH)+1 bits each, so full and empty can be told apart.
- No state machine beyond the FIFO's pointer state; the block is a datapath plus a buffer.

Decomposition:
- No shared package is needed.
- Derived localparams, defined locally in the module:
  - TS_W = EPOCH_W+16.
  - PTR_W = $clog2(FIFO_DEPTH).
- One sub-module, tagger_sync_fifo:
  - Parameterised width and depth; asynchronous active-high reset.
  - Ports: push, din, full, pop, dout, empty.
  - Reused later by the host readout path.

Test Plan:
- Reset then idle with counter free-running 0..0xFFFF, and rollover pulsed at each 0 -> epoch increments once per pulse: 0, 1, 2; tag_valid stays 0.
- Event at epoch=3, counter=0x1234, channel 2, tag_ready=1 -> next cycle tag_valid=1, tag_time=0x0000_0003_1234, tag_channel=2; then tag_valid=0.
- Event in the rollover cycle with epoch=7, counter=0x0000 -> tag_time=0x0000_0008_0000, and epoch reads 8 one cycle later.
- tag_ready=0 and 10 events with channels 0..9, FIFO_DEPTH=8 -> 8 words stored, overflow=1, dropped=2; with tag_ready=1, words come out for channels 0..7 in order with timestamps unchanged.
- FIFO full with pop and event in the same cycle -> event dropped (dropped increments), occupancy becomes 7.
- Assert rst mid-burst with 5 words queued -> tag_valid falls to 0 immediately (asynchronously); epoch, dropped and overflow read 0; the next event gives a word with epoch 0.
